// File: rtl/game_sequencer_if.sv
// Bundle between the button/collision logic, the game sequencer
// and the renderer: game inputs in, screen selects and scores out.
interface game_sequencer_if #(
  parameter int SCORE_W = 8
);

  logic               play;
  logic               tick;
  logic               collision;
  logic               pass;

  logic [2:0]         state;
  logic               run;
  logic               show_start;
  logic               show_over;
  logic               flash;
  logic [1:0]         countdown;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hiscore;
  logic               new_best;

  modport master (
    output play,
    output tick,
    output collision,
    output pass,
    input  state,
    input  run,
    input  show_start,
    input  show_over,
    input  flash,
    input  countdown,
    input  score,
    input  hiscore,
    input  new_best
  );

  modport slave (
    input  play,
    input  tick,
    input  collision,
    input  pass,
    output state,
    output run,
    output show_start,
    output show_over,
    output flash,
    output countdown,
    output score,
    output hiscore,
    output new_best
  );

endinterface

// File: rtl/game_sequencer.sv
// Flappy Bird game flow: play screen, countdown, run, death flash,
// game over and retry, with current/high score keeping.
module game_sequencer #(
  parameter int COUNT_TICKS = 3,
  parameter int FLASH_TICKS = 8,
  parameter int SCORE_W     = 8
) (
  input  logic            clk,
  input  logic            reset,
  game_sequencer_if.slave bus
);

  localparam int MAXT =
    (COUNT_TICKS > FLASH_TICKS) ?
    COUNT_TICKS : FLASH_TICKS;
  localparam int CNT_W =
    (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CNT_W-1:0] CNT_START =
    CNT_W'(COUNT_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_START =
    CNT_W'(FLASH_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    RUN   = 3'd2,
    DIE   = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               play_q;
  logic               press;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_zero;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] hiscore_q;
  logic               flash_q;
  logic               new_best_q;
  logic [1:0]         cd_sat;

  // play_q resets high so a button held through reset is not a press
  assign press    = bus.play & ~play_q;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        state_d = press ? COUNT : IDLE;
      end
      COUNT: begin
        state_d = (bus.tick && cnt_zero) ?
                  RUN : COUNT;
      end
      RUN: begin
        state_d = bus.collision ? DIE : RUN;
      end
      DIE: begin
        state_d = (bus.tick && cnt_zero) ?
                  OVER : DIE;
      end
      OVER: begin
        state_d = press ? COUNT : OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      play_q     <= 1'b1;
      cnt_q      <= '0;
      score_q    <= '0;
      hiscore_q  <= '0;
      flash_q    <= 1'b0;
      new_best_q <= 1'b0;
    end else begin
      play_q     <= bus.play;
      new_best_q <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          flash_q <= 1'b0;
          if (press) begin
            score_q <= '0;
            cnt_q   <= CNT_START;
          end
        end
        COUNT: begin
          if (bus.tick && !cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RUN: begin
          // collision beats a same-cycle pass
          if (bus.collision) begin
            cnt_q   <= FLASH_START;
            flash_q <= 1'b1;
          end else if (bus.pass &&
                       score_q != SCORE_MAX) begin
            score_q <= score_q + 1'b1;
          end
        end
        DIE: begin
          if (bus.tick) begin
            flash_q <= ~flash_q;
            if (!cnt_zero) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (score_q > hiscore_q) begin
              hiscore_q  <= score_q;
              new_best_q <= 1'b1;
            end
          end
        end
        default: begin
          flash_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cd_sat = 2'(cnt_q);
    if (32'(cnt_q) > 32'd3) begin
      cd_sat = 2'd3;
    end
  end

  always_comb begin
    bus.state      = state_q;
    bus.run        = 1'b0;
    bus.show_start = 1'b0;
    bus.show_over  = 1'b0;
    bus.flash      = 1'b0;
    bus.countdown  = 2'd0;
    bus.score      = score_q;
    bus.hiscore    = hiscore_q;
    bus.new_best   = new_best_q;
    unique case (1'b1)
      state_q == IDLE:  bus.show_start = 1'b1;
      state_q == COUNT: bus.countdown  = cd_sat;
      state_q == RUN:   bus.run        = 1'b1;
      state_q == DIE:   bus.flash      = flash_q;
      state_q == OVER:  bus.show_over  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: two instances (8-bit and
// 2-bit scores) share random stimulus against a game-level model.
module tb_game_sequencer;

  localparam int CT = 3;
  localparam int FT = 8;

  typedef struct {
    int st;
    int run;
    int start;
    int over;
    int flash;
    int cd;
    int score;
    int hi;
    int nb;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_sequencer_if #(.SCORE_W(8)) ia ();
  game_sequencer_if #(.SCORE_W(2)) ib ();

  game_sequencer #(
    .COUNT_TICKS(CT),
    .FLASH_TICKS(FT),
    .SCORE_W(8)
  ) dut_a (
    .clk(clk),
    .reset(reset),
    .bus(ia.slave)
  );

  game_sequencer #(
    .COUNT_TICKS(CT),
    .FLASH_TICKS(FT),
    .SCORE_W(2)
  ) dut_b (
    .clk(clk),
    .reset(reset),
    .bus(ib.slave)
  );

  int checks = 0;
  int errors = 0;

  obs_t qa[$];
  obs_t qb[$];

  // game model: phase 0 idle,1 count,2 run,3 die,4 over
  int phase[2];
  int left[2];
  int sc[2];
  int hs[2];
  int fl[2];
  int nb[2];
  int pq[2];
  int smax[2];

  task automatic chk(string tag, string name,
                     int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d",
               tag, name, act, exp);
    end
  endtask

  task automatic cmp(string tag, obs_t a, obs_t e);
    chk(tag, "state", a.st, e.st);
    chk(tag, "run", a.run, e.run);
    chk(tag, "show_start", a.start, e.start);
    chk(tag, "show_over", a.over, e.over);
    chk(tag, "flash", a.flash, e.flash);
    chk(tag, "countdown", a.cd, e.cd);
    chk(tag, "score", a.score, e.score);
    chk(tag, "hiscore", a.hi, e.hi);
    chk(tag, "new_best", a.nb, e.nb);
  endtask

  function automatic obs_t get_a();
    obs_t o;
    o.st    = int'(ia.state);
    o.run   = int'(ia.run);
    o.start = int'(ia.show_start);
    o.over  = int'(ia.show_over);
    o.flash = int'(ia.flash);
    o.cd    = int'(ia.countdown);
    o.score = int'(ia.score);
    o.hi    = int'(ia.hiscore);
    o.nb    = int'(ia.new_best);
    return o;
  endfunction

  function automatic obs_t get_b();
    obs_t o;
    o.st    = int'(ib.state);
    o.run   = int'(ib.run);
    o.start = int'(ib.show_start);
    o.over  = int'(ib.show_over);
    o.flash = int'(ib.flash);
    o.cd    = int'(ib.countdown);
    o.score = int'(ib.score);
    o.hi    = int'(ib.hiscore);
    o.nb    = int'(ib.new_best);
    return o;
  endfunction

  function automatic obs_t model_obs(int i);
    obs_t o;
    o.st    = phase[i];
    o.run   = (phase[i] == 2) ? 1 : 0;
    o.start = (phase[i] == 0) ? 1 : 0;
    o.over  = (phase[i] == 4) ? 1 : 0;
    o.flash = (phase[i] == 3) ? fl[i] : 0;
    o.cd    = 0;
    if (phase[i] == 1) begin
      o.cd = (left[i] - 1 > 3) ? 3 : left[i] - 1;
    end
    o.score = sc[i];
    o.hi    = hs[i];
    o.nb    = nb[i];
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0;
      left[i]  = 0;
      sc[i]    = 0;
      hs[i]    = 0;
      fl[i]    = 0;
      nb[i]    = 0;
      pq[i]    = 1;
    end
  endtask

  task automatic model_step(int p, int t, int c, int s);
    bit press;
    for (int i = 0; i < 2; i++) begin
      press = (p != 0) && (pq[i] == 0);
      pq[i] = p;
      nb[i] = 0;
      case (phase[i])
        0, 4: begin
          if (press) begin
            phase[i] = 1;
            left[i]  = CT;
            sc[i]    = 0;
          end
        end
        1: begin
          if (t != 0) begin
            left[i]--;
            if (left[i] == 0) phase[i] = 2;
          end
        end
        2: begin
          if (c != 0) begin
            phase[i] = 3;
            left[i]  = FT;
            fl[i]    = 1;
          end else if (s != 0 && sc[i] < smax[i]) begin
            sc[i]++;
          end
        end
        3: begin
          if (t != 0) begin
            fl[i] ^= 1;
            left[i]--;
            if (left[i] == 0) begin
              phase[i] = 4;
              if (sc[i] > hs[i]) begin
                hs[i] = sc[i];
                nb[i] = 1;
              end
            end
          end
        end
        default: phase[i] = 0;
      endcase
    end
  endtask

  task automatic drive(int p, int t, int c, int s);
    ia.play      = (p != 0);
    ib.play      = (p != 0);
    ia.tick      = (t != 0);
    ib.tick      = (t != 0);
    ia.collision = (c != 0);
    ib.collision = (c != 0);
    ia.pass      = (s != 0);
    ib.pass      = (s != 0);
  endtask

  // called at a negedge: drive, predict, then wait one cycle
  task automatic step(int p, int t, int c, int s);
    drive(p, t, c, s);
    model_step(p, t, c, s);
    qa.push_back(model_obs(0));
    qb.push_back(model_obs(1));
    @(negedge clk);
  endtask

  task automatic do_reset(int hold_play, string tag);
    #2;
    reset = 1'b0;
    drive(hold_play, 0, 0, 0);
    model_reset();
    #1;
    cmp({tag, ".a"}, get_a(), model_obs(0));
    cmp({tag, ".b"}, get_b(), model_obs(1));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) cmp("a", get_a(), qa.pop_front());
      if (qb.size() > 0) cmp("b", get_b(), qb.pop_front());
    end
  end

  initial begin
    int p;
    smax[0] = 255;
    smax[1] = 3;
    reset = 1'b0;
    drive(1, 0, 0, 0);
    model_reset();
    #1;
    cmp("rst0.a", get_a(), model_obs(0));
    cmp("rst0.b", get_b(), model_obs(1));
    @(negedge clk);
    reset = 1'b1;

    // held button through reset, then a real press
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    // countdown
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    // five passes, then collision with pass
    repeat (5) begin
      step(0, 0, 0, 1);
      step(1, 0, 0, 0);
    end
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    // death flash into game over
    repeat (FT) begin
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    // retry reaching an equal score
    step(1, 0, 0, 0);
    repeat (CT) step(0, 1, 0, 0);
    repeat (5) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    repeat (FT) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    // reset asserted mid-run with score 4
    step(1, 0, 0, 0);
    repeat (CT) step(0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 1);
    do_reset(0, "rst_run");

    p = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) p = 1 - p;
      if ($urandom_range(700) == 0) begin
        do_reset(p, "rst_rand");
      end
      step(p,
           ($urandom_range(2) == 0) ? 1 : 0,
           ($urandom_range(39) == 0) ? 1 : 0,
           ($urandom_range(3) == 0) ? 1 : 0);
    end
    drive(p, 0, 0, 0);
    @(negedge clk);
    chk("end", "drain_a", qa.size(), 0);
    chk("end", "drain_b", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
